window_col_buffer: RTL and testbench
====================================

# window_col_buffer

Parametrised ping-pong column window buffer for the convolution datapath. It assembles K×K feature windows for TN input channels, one column per cycle, from either of two column sources. Run-time kernel size is 1..KMAX. It sits between the feature line buffers and the select/PE array. Double banking lets one window drain while the next fills, and valid/ready handshakes on both sides let either end stall.

## Interface
- TN, 4, input channel groups per window
- KMAX, 5, maximum kernel size; window storage is KMAX×KMAX per group
- FEATURE_WIDTH, 16, bits per pixel
- KS_W, 4, width of kernel_size port
---
- clk  input  1  single clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear of both banks; error flag preserved
- kernel_size  input  KS_W  run-time K; sampled on the first column of each window
- in_select  input  1  source select (0: col_data_0, 1: col_data_1); sampled on the first column of each window
- col_valid  input  1  column offered
- col_ready  output  1  column can be accepted
- col_data_0  input  TN*KMAX*FEATURE_WIDTH  source 0 column; group g occupies slice g, row r at sub-slice r
- col_data_1  input  TN*KMAX*FEATURE_WIDTH  source 1 column, same packing
- win_valid  output  1  a complete window is presented
- win_ready  input  1  consumer accepts the window
- win_data  output  TN*KMAX*KMAX*FEATURE_WIDTH  group g at slice g; within a group, column c (0 = newest) at sub-slice c of KMAX*FEATURE_WIDTH
- win_ksize  output  KS_W  K of the presented window
- busy  output  1  either bank is FILLING or FULL
- err_ksize  output  1  sticky; set when an illegal kernel_size was sampled

## Operation
- Two banks, each with a state of EMPTY, FILLING or FULL, a column counter (0..KMAX-1), a latched K and a latched source.
- wr_bank points to the filling side and rd_bank to the draining side. Both are 0 after reset or flush.
- Column accept: col_valid && col_ready. col_ready = (state[wr_bank] != FULL).
- Accept while EMPTY:
  - Latch K and source.
  - Bank data becomes {zeros, masked column}.
  - counter = 1.
  - Next state is FULL if K == 1, otherwise FILLING.
- Accept while FILLING:
  - Shift in: data = {data[lower (KMAX-1) columns], masked column}.
  - counter++.
  - At counter == K-1 the bank goes FULL and wr_bank toggles.
- Masking: rows r >= K of each incoming column are forced to 0. Columns beyond K stay 0 from the first-column clear. Data is therefore zero-padded at high indices.
- Source mux uses the latched source for columns 2..K. For column 1 it uses in_select directly.
- Illegal K (0 or > KMAX): K is treated as KMAX and err_ksize is set. err_ksize is cleared only by rst.
- Drain: win_valid = (state[rd_bank] == FULL). win_data and win_ksize come from bank[rd_bank]. On win_valid && win_ready the bank goes EMPTY and rd_bank toggles.
- Simultaneous fill-complete on one bank and drain on the other in the same cycle are both honoured.
- flush (or rst): both banks go EMPTY, counters and pointers go to 0, data goes to 0. flush has priority over any concurrent accept or drain in that cycle.
- Arithmetic: counter and K compare are at KS_W bits; no wrap occurs because the counter stops at K-1.

## Timing
- Reset values:
  - col_ready = 1
  - win_valid = 0
  - win_data = 0
  - win_ksize = 0
  - busy = 0
  - err_ksize = 0
- All outputs are functions of registers only; there is no combinational path from any input to any output.
- Latency: the K-th column accepted at edge t gives win_valid = 1 after edge t (visible in cycle t+1).
- Sustained throughput is one window per K cycles when win_ready is held at 1. col_ready never deasserts in that case.
- If both banks are FULL, col_ready = 0. It reasserts in the cycle after the drain handshake.
- win_data and win_ksize must remain stable while win_valid && !win_ready.
- err_ksize asserts in the cycle after the offending sample.

## Test plan
- K=5, TN=4, continuous col_valid with in_select=0, column n rows = n*16+r, win_ready=1 -> win_valid first high 1 cycle after the 5th accept. Group 0 column 0 holds the 5th column and column 4 holds the 1st. One window every 5 cycles, col_ready always 1.
- K=3, in_select=1 on the first column then toggled -> all 3 columns are taken from col_data_1. Rows 3-4 and columns 3-4 of every group are 0. win_ksize = 3.
- win_ready=0 while 10 columns are fed at K=5 -> both banks go FULL and col_ready drops after the 10th accept. Then win_ready=1 for 1 cycle -> first window drained, col_ready=1 the next cycle, second window presented unchanged.
- K=1 -> every accepted column produces a window 1 cycle later; only row 0 of column 0 is nonzero.
- kernel_size=7 with KMAX=5 -> err_ksize rises after the first column and stays high. The window completes after 5 columns. A later flush does not clear err_ksize; rst does.
- Assert flush mid-fill (after 2 of 5 columns) concurrent with col_valid -> that column is dropped, busy=0 next cycle, and the next window starts clean with win_data free of stale columns.

Source files
------------

// File: rtl/window_col_buffer.sv
// Ping-pong column window buffer: assembles KxK windows for TN channel groups one
// column per cycle into one bank while the other bank drains to the PE array.
module window_col_buffer #(
  parameter int unsigned TN            = 4,
  parameter int unsigned KMAX          = 5,
  parameter int unsigned FEATURE_WIDTH = 16,
  parameter int unsigned KS_W          = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [KS_W-1:0]                       kernel_size,
  input  logic                                  in_select,
  input  logic                                  col_valid,
  output logic                                  col_ready,
  input  logic [TN*KMAX*FEATURE_WIDTH-1:0]      col_data_0,
  input  logic [TN*KMAX*FEATURE_WIDTH-1:0]      col_data_1,
  output logic                                  win_valid,
  input  logic                                  win_ready,
  output logic [TN*KMAX*KMAX*FEATURE_WIDTH-1:0] win_data,
  output logic [KS_W-1:0]                       win_ksize,
  output logic                                  busy,
  output logic                                  err_ksize
);

  localparam int unsigned COL_W = KMAX * FEATURE_WIDTH;
  localparam int unsigned GRP_W = KMAX * COL_W;
  localparam int unsigned IN_W  = TN * COL_W;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  localparam logic [KS_W-1:0] KMAX_K = KS_W'(KMAX);
  localparam logic [KS_W-1:0] ONE_K  = KS_W'(1);

  logic [1:0]       state_q [2];
  logic [1:0]       state_d [2];
  logic [KS_W-1:0]  cnt_q   [2];
  logic [KS_W-1:0]  cnt_d   [2];
  logic [KS_W-1:0]  k_q     [2];
  logic [KS_W-1:0]  k_d     [2];
  logic             src_q   [2];
  logic             src_d   [2];
  logic [COL_W-1:0] data_q  [2][TN][KMAX];
  logic [COL_W-1:0] data_d  [2][TN][KMAX];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic             err_q, err_d;

  logic             accept;
  logic             drain;
  logic             ks_illegal;
  logic             wr_empty;
  logic             src_use;
  logic [KS_W-1:0]  k_use;
  logic [IN_W-1:0]  col_sel;
  logic [COL_W-1:0] masked [TN];

  assign col_ready = (state_q[wr_bank_q] != ST_FULL);
  assign win_valid = (state_q[rd_bank_q] == ST_FULL);
  assign win_ksize = k_q[rd_bank_q];
  assign busy      = (state_q[0] != ST_EMPTY) || (state_q[1] != ST_EMPTY);
  assign err_ksize = err_q;
  assign accept    = col_valid && col_ready;
  assign drain     = win_valid && win_ready;

  // First column of a window takes K and source live; later columns use the latched copies.
  always_comb begin
    ks_illegal = (kernel_size == '0) || (kernel_size > KMAX_K);
    wr_empty   = (state_q[wr_bank_q] == ST_EMPTY);
    k_use      = wr_empty ? (ks_illegal ? KMAX_K : kernel_size) : k_q[wr_bank_q];
    src_use    = wr_empty ? in_select : src_q[wr_bank_q];
    col_sel    = src_use ? col_data_1 : col_data_0;
    for (int g = 0; g < TN; g++) begin
      masked[g] = '0;
      for (int r = 0; r < KMAX; r++) begin
        if (KS_W'(r) < k_use)
          masked[g][r*FEATURE_WIDTH +: FEATURE_WIDTH] =
            col_sel[g*COL_W + r*FEATURE_WIDTH +: FEATURE_WIDTH];
      end
    end
  end

  // Bank state update; drain and fill never target the same bank in one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    src_d     = src_q;
    data_d    = data_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    err_d     = err_q;

    if (flush) begin
      for (int b = 0; b < 2; b++) begin
        state_d[b] = ST_EMPTY;
        cnt_d[b]   = '0;
        k_d[b]     = '0;
        src_d[b]   = 1'b0;
        for (int g = 0; g < TN; g++)
          for (int c = 0; c < KMAX; c++)
            data_d[b][g][c] = '0;
      end
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
    end else begin
      if (drain) begin
        state_d[rd_bank_q] = ST_EMPTY;
        rd_bank_d          = ~rd_bank_q;
      end
      if (accept) begin
        if (wr_empty) begin
          k_d[wr_bank_q]   = k_use;
          src_d[wr_bank_q] = in_select;
          cnt_d[wr_bank_q] = ONE_K;
          err_d            = err_q | ks_illegal;
          for (int g = 0; g < TN; g++)
            for (int c = 0; c < KMAX; c++)
              data_d[wr_bank_q][g][c] = (c == 0) ? masked[g] : '0;
          if (k_use == ONE_K) begin
            state_d[wr_bank_q] = ST_FULL;
            wr_bank_d          = ~wr_bank_q;
          end else begin
            state_d[wr_bank_q] = ST_FILLING;
          end
        end else begin
          for (int g = 0; g < TN; g++) begin
            data_d[wr_bank_q][g][0] = masked[g];
            for (int c = 1; c < KMAX; c++)
              data_d[wr_bank_q][g][c] = data_q[wr_bank_q][g][c-1];
          end
          if (cnt_q[wr_bank_q] == (k_q[wr_bank_q] - ONE_K)) begin
            state_d[wr_bank_q] = ST_FULL;
            wr_bank_d          = ~wr_bank_q;
          end else begin
            cnt_d[wr_bank_q] = cnt_q[wr_bank_q] + ONE_K;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= ST_EMPTY;
        cnt_q[b]   <= '0;
        k_q[b]     <= '0;
        src_q[b]   <= 1'b0;
        for (int g = 0; g < TN; g++)
          for (int c = 0; c < KMAX; c++)
            data_q[b][g][c] <= '0;
      end
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      src_q     <= src_d;
      data_q    <= data_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      err_q     <= err_d;
    end
  end

  // Present the draining bank; column 0 is the newest.
  always_comb begin
    win_data = '0;
    for (int g = 0; g < TN; g++)
      for (int c = 0; c < KMAX; c++)
        win_data[g*GRP_W + c*COL_W +: COL_W] = data_q[rd_bank_q][g][c];
  end

endmodule

// File: tb/tb_window_col_buffer.sv
// Bench for window_col_buffer: directed and random column traffic checked against a
// queue-based window model.
module tb_window_col_buffer;

  localparam int unsigned TN    = 4;
  localparam int unsigned KMAX  = 5;
  localparam int unsigned FW    = 16;
  localparam int unsigned KS_W  = 4;
  localparam int unsigned COL_W = KMAX * FW;
  localparam int unsigned GRP_W = KMAX * COL_W;
  localparam int unsigned IN_W  = TN * COL_W;
  localparam int unsigned WIN_W = TN * GRP_W;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [KS_W-1:0]  kernel_size;
  logic             in_select;
  logic             col_valid;
  logic             col_ready;
  logic [IN_W-1:0]  col_data_0;
  logic [IN_W-1:0]  col_data_1;
  logic             win_valid;
  logic             win_ready;
  logic [WIN_W-1:0] win_data;
  logic [KS_W-1:0]  win_ksize;
  logic             busy;
  logic             err_ksize;

  window_col_buffer #(
    .TN(TN), .KMAX(KMAX), .FEATURE_WIDTH(FW), .KS_W(KS_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .kernel_size(kernel_size),
    .in_select(in_select), .col_valid(col_valid), .col_ready(col_ready),
    .col_data_0(col_data_0), .col_data_1(col_data_1),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_ksize(win_ksize), .busy(busy), .err_ksize(err_ksize)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: columns of the window being assembled (oldest first) and completed windows.
  logic [IN_W-1:0]  part [$];
  logic [WIN_W-1:0] pend_w [$];
  int               pend_k [$];
  int               cur_k;
  bit               cur_src;
  bit               m_err;

  task automatic check(input string tag, input logic [GRP_W-1:0] obs, input logic [GRP_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] mask_col(input logic [IN_W-1:0] col, input int k);
    logic [IN_W-1:0] m;
    m = col;
    for (int g = 0; g < TN; g++)
      for (int r = 0; r < KMAX; r++)
        if (r >= k) m[g*COL_W + r*FW +: FW] = '0;
    return m;
  endfunction

  task automatic check_outputs();
    logic [WIN_W-1:0] hw;
    check("col_ready", GRP_W'(col_ready), GRP_W'(pend_w.size() < 2));
    check("win_valid", GRP_W'(win_valid), GRP_W'(pend_w.size() > 0));
    check("busy", GRP_W'(busy), GRP_W'((pend_w.size() > 0) || (part.size() > 0)));
    check("err_ksize", GRP_W'(err_ksize), GRP_W'(m_err));
    if (pend_w.size() > 0) begin
      hw = pend_w[0];
      check("win_ksize", GRP_W'(win_ksize), GRP_W'(pend_k[0]));
      for (int g = 0; g < TN; g++)
        check($sformatf("win_grp%0d", g), win_data[g*GRP_W +: GRP_W], hw[g*GRP_W +: GRP_W]);
    end
  endtask

  // One cycle: check what the last edge produced, drive new inputs, advance the model.
  task automatic step(input bit v, input bit sel, input logic [KS_W-1:0] ks, input bit wr, input bit fl);
    bit               acc;
    bit               drn;
    logic [IN_W-1:0]  pc;
    logic [WIN_W-1:0] w;
    int               c;
    @(negedge clk);
    check_outputs();
    col_valid   = v;
    in_select   = sel;
    kernel_size = ks;
    win_ready   = wr;
    flush       = fl;
    for (int i = 0; i < IN_W / 32; i++) begin
      col_data_0[i*32 +: 32] = $urandom;
      col_data_1[i*32 +: 32] = $urandom;
    end
    acc = v && (pend_w.size() < 2);
    drn = wr && (pend_w.size() > 0);
    if (fl) begin
      part.delete();
      pend_w.delete();
      pend_k.delete();
    end else begin
      if (drn) begin
        void'(pend_w.pop_front());
        void'(pend_k.pop_front());
      end
      if (acc) begin
        if (part.size() == 0) begin
          cur_k   = int'(ks);
          cur_src = sel;
          if (ks == 0 || ks > KMAX) begin
            cur_k = KMAX;
            m_err = 1'b1;
          end
        end
        part.push_back(mask_col(cur_src ? col_data_1 : col_data_0, cur_k));
        if (part.size() == cur_k) begin
          w = '0;
          for (int j = 0; j < cur_k; j++) begin
            pc = part[j];
            c  = cur_k - 1 - j;
            for (int g = 0; g < TN; g++)
              w[g*GRP_W + c*COL_W +: COL_W] = pc[g*COL_W +: COL_W];
          end
          pend_w.push_back(w);
          pend_k.push_back(cur_k);
          part.delete();
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    flush     = 1'b0;
    col_valid = 1'b0;
    win_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    part.delete();
    pend_w.delete();
    pend_k.delete();
    m_err = 1'b0;
    check("rst_win_ksize", GRP_W'(win_ksize), '0);
    for (int g = 0; g < TN; g++)
      check($sformatf("rst_win_grp%0d", g), win_data[g*GRP_W +: GRP_W], '0);
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; kernel_size = '0; in_select = 1'b0;
    col_valid = 1'b0; win_ready = 1'b0; col_data_0 = '0; col_data_1 = '0;
    cur_k = 0; cur_src = 1'b0; m_err = 1'b0;
    do_reset();

    // K=5 streaming, consumer always ready
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 4'd5, 1'b1, 1'b0);
    // K=3, source 1 on first column then toggling
    for (int i = 0; i < 9; i++) step(1'b1, (i % 3 == 0) ? 1'b1 : bit'(i % 2), 4'd3, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
    // Backpressure: fill both banks, then drain one for a single cycle
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 4'd5, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
    // K=1: one window per column
    for (int i = 0; i < 6; i++) step(1'b1, bit'(i % 2), 4'd1, 1'b1, 1'b0);
    // Flush mid-fill with a concurrent column, then a clean window
    step(1'b1, 1'b0, 4'd5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd5, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(i < 5, 1'b1, 4'd5, 1'b1, 1'b0);
    // Random traffic with legal kernel sizes
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, bit'($urandom_range(0, 1)), KS_W'($urandom_range(1, KMAX)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    step(1'b0, 1'b0, 4'd5, 1'b0, 1'b1);
    // Illegal kernel size: treated as KMAX, sticky error
    for (int i = 0; i < 8; i++) step(i < 5, 1'b0, 4'd7, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'd5, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
    // Only rst clears the error flag
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'd2, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
